// File: rtl/rmii_rx_frame_filter.sv
// rmii_rx_frame_filter: destination-MAC filter, FCS strip, CRC-32 and length check between RMII_RX and the RX FIFO.
// Each passed frame is followed by a one-cycle status word; all outputs are registered.
module rmii_rx_frame_filter #(
  parameter logic [47:0] MAC_ADDR = 48'h0200_0000_0001,
  parameter int          MIN_LEN  = 64,
  parameter int          MAX_LEN  = 1518
) (
  input  logic        REF_CLK,
  input  logic        arst,
  input  logic [7:0]  in_din,
  input  logic        in_wren,
  input  logic        in_EOD,
  input  logic        promisc,
  input  logic        out_afull,
  output logic [7:0]  out_din,
  output logic        out_wren,
  output logic        out_EOD,
  output logic        stat_valid,
  output logic        stat_crc_err,
  output logic        stat_len_err,
  output logic        stat_ovf,
  output logic [10:0] stat_len,
  output logic [15:0] drop_cnt
);
  typedef enum logic [2:0] {IDLE, HDR, PASS, DROP, FLUSH1, FLUSH2, STATUS} state_t;
  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d, stat_len_q, stat_len_d;
  logic [47:0] sr_q, sr_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] drop_q, drop_d;
  logic        ovf_q, ovf_d, late_cur_q, late_cur_d, late_nxt_q, late_nxt_d;
  logic [7:0]  out_din_q, out_din_d;
  logic        out_wren_q, out_wren_d, out_eod_q, out_eod_d;
  logic        stat_valid_q, stat_valid_d, stat_crc_q, stat_crc_d;
  logic        stat_lerr_q, stat_lerr_d, stat_ovf_q, stat_ovf_d;
  logic        emit;
  logic [7:0]  emit_byte;
  logic [10:0] cnt_inc;
  logic [47:0] sr_sh;
  logic [31:0] crc_nx;
  logic        accept;

  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 11'd1;
  assign sr_sh   = {sr_q[39:0], in_din};
  assign crc_nx  = crc_byte(crc_q, in_din);
  assign accept  = promisc || (sr_sh == MAC_ADDR) || (&sr_sh);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    crc_d        = crc_q;
    drop_d       = drop_q;
    ovf_d        = ovf_q;
    late_cur_d   = late_cur_q;
    late_nxt_d   = late_nxt_q;
    out_din_d    = out_din_q;
    out_wren_d   = 1'b0;
    out_eod_d    = 1'b0;
    stat_valid_d = 1'b0;
    stat_crc_d   = stat_crc_q;
    stat_lerr_d  = stat_lerr_q;
    stat_ovf_d   = stat_ovf_q;
    stat_len_d   = stat_len_q;
    emit         = 1'b0;
    emit_byte    = sr_q[47:40];
    case (state_q)
      IDLE: begin
        if (in_wren && in_EOD) begin
          drop_d = drop_q + 16'd1;
        end else if (in_wren) begin
          cnt_d   = 11'd1;
          sr_d    = {40'h0, in_din};
          crc_d   = crc_byte(32'hFFFF_FFFF, in_din);
          ovf_d   = 1'b0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (in_wren) begin
          cnt_d = cnt_inc;
          sr_d  = sr_sh;
          crc_d = crc_nx;
        end
        if (in_wren && cnt_q == 11'd5) begin
          state_d = !accept ? (in_EOD ? IDLE : DROP) : (in_EOD ? FLUSH1 : PASS);
          if (!accept && in_EOD) drop_d = drop_q + 16'd1;
        end else if (in_EOD) begin
          state_d = IDLE;
          drop_d  = drop_q + 16'd1;
        end
      end
      PASS: begin
        if (in_wren) begin
          cnt_d = cnt_inc;
          sr_d  = sr_sh;
          crc_d = crc_nx;
          emit  = 1'b1;
        end
        if (in_EOD) state_d = FLUSH1;
      end
      DROP: begin
        if (in_wren) cnt_d = cnt_inc;
        if (in_EOD) begin
          state_d = IDLE;
          drop_d  = drop_q + 16'd1;
        end
      end
      FLUSH1: begin
        emit       = 1'b1;
        late_nxt_d = late_nxt_q | in_wren;
        state_d    = FLUSH2;
      end
      FLUSH2: begin
        emit       = 1'b1;
        emit_byte  = sr_q[39:32];
        late_nxt_d = late_nxt_q | in_wren;
        state_d    = STATUS;
      end
      STATUS: begin
        stat_valid_d = 1'b1;
        stat_crc_d   = crc_q != RESIDUE;
        stat_lerr_d  = (cnt_q < MIN_L) || (cnt_q > MAX_L);
        stat_ovf_d   = ovf_q | late_cur_q;
        stat_len_d   = cnt_q - 11'd4;
        // a byte arriving during this frame's tail is charged to the next frame's status
        late_cur_d   = late_nxt_q | in_wren;
        late_nxt_d   = 1'b0;
        cnt_d        = 11'd0;
        crc_d        = 32'hFFFF_FFFF;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // once afull hits, the rest of the frame (including the EOD byte) is suppressed
    if (emit) begin
      if (out_afull || ovf_q) begin
        ovf_d = 1'b1;
      end else begin
        out_wren_d = 1'b1;
        out_din_d  = emit_byte;
        out_eod_d  = state_q == FLUSH2;
      end
    end
  end

  always_ff @(posedge REF_CLK or posedge arst) begin
    if (arst) begin
      state_q      <= IDLE;
      cnt_q        <= 11'd0;
      sr_q         <= 48'h0;
      crc_q        <= 32'hFFFF_FFFF;
      drop_q       <= 16'd0;
      ovf_q        <= 1'b0;
      late_cur_q   <= 1'b0;
      late_nxt_q   <= 1'b0;
      out_din_q    <= 8'h0;
      out_wren_q   <= 1'b0;
      out_eod_q    <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_crc_q   <= 1'b0;
      stat_lerr_q  <= 1'b0;
      stat_ovf_q   <= 1'b0;
      stat_len_q   <= 11'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      crc_q        <= crc_d;
      drop_q       <= drop_d;
      ovf_q        <= ovf_d;
      late_cur_q   <= late_cur_d;
      late_nxt_q   <= late_nxt_d;
      out_din_q    <= out_din_d;
      out_wren_q   <= out_wren_d;
      out_eod_q    <= out_eod_d;
      stat_valid_q <= stat_valid_d;
      stat_crc_q   <= stat_crc_d;
      stat_lerr_q  <= stat_lerr_d;
      stat_ovf_q   <= stat_ovf_d;
      stat_len_q   <= stat_len_d;
    end
  end

  assign out_din      = out_din_q;
  assign out_wren     = out_wren_q;
  assign out_EOD      = out_eod_q;
  assign stat_valid   = stat_valid_q;
  assign stat_crc_err = stat_crc_q;
  assign stat_len_err = stat_lerr_q;
  assign stat_ovf     = stat_ovf_q;
  assign stat_len     = stat_len_q;
  assign drop_cnt     = drop_q;
endmodule
